bcd_entry_ctrl: RTL
===================

Name: bcd_entry_ctrl

Overview:
Synchronous, parametrised BCD number-entry controller for the board demo designs. The user enters digits on SW[3:0], least-significant digit first, and commits each one with a key press. Backspace, sign toggle and optional restart are supported. The block drives a packed per-digit code bus plus a sign code into the existing seven_seg decoders. Codes are 0-9 for digits, 4'hA for OFF (blank) and 4'hB for NEGATIVE. It sits between the board KEY/SW pins and the HEX display instances, and replaces ad-hoc negedge-KEY entry logic.

Parameters:
NUM_DIGITS, 3, number of entry digits (1..8)
DEBOUNCE_CYCLES, 500000, clk cycles a key level must stay stable before it is accepted (>=2)
WRAP_EN, 0, 1 = an enter press in DONE clears the value and restarts entry; 0 = enter is ignored in DONE
BLANK_UNUSED, 0, 1 = positions above the cursor show OFF; 0 = they show their stored value (reset value 0)

Ports:
clk  input  1  system clock (CLOCK_50)
rst  input  1  synchronous reset, active-low
key_enter_n  input  1  raw enter key, active-low, asynchronous to clk
key_back_n  input  1  raw backspace key, active-low, asynchronous
key_sign_n  input  1  raw sign-toggle key, active-low, asynchronous
sw_digit  input  4  candidate digit from the switches
digits_out  output  4*NUM_DIGITS  per-position display codes, position 0 in [3:0]
sign_out  output  4  4'hB when negative, 4'hA when positive
cursor  output  clog2(NUM_DIGITS+1)  next position to be written
entry_done  output  1  high while in DONE
err_pulse  output  1  one-cycle pulse when an enter press is rejected

Behaviour:
- Reset: one clock with rst low at a rising edge sets the following.
  - All stored digits = 0, cursor = 0, negative = 0, state = ENTRY.
  - entry_done = 0, err_pulse = 0.
  - Synchronisers and debounce counters are cleared; debounced key levels = 1 (released).
  - Reset overrides any event in the same cycle, including mid-debounce.
- Key conditioning, per key, independent:
  - 2-flop synchroniser feeds a stable counter.
  - The debounced level changes only after the synchronised level has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  - A press event is a one-cycle pulse on a debounced 1->0 transition. Release generates nothing. Holding a key gives exactly one event.
- Latency: the state update occurs on the clock edge after the press pulse. Raw stable low to visible update = 2 + DEBOUNCE_CYCLES + 1 cycles.
- States: ENTRY, DONE. Registered outputs.
- ENTRY, enter event:
  - If sw_digit <= 9: store it at position cursor and increment cursor.
  - If cursor becomes NUM_DIGITS, go to DONE.
  - If sw_digit > 9: no store, no cursor change, err_pulse = 1 for one cycle.
- ENTRY, back event:
  - If cursor > 0: cursor decrements and the stored digit at the new cursor is cleared to 0.
  - If cursor = 0: no effect.
- DONE, back event: cursor = NUM_DIGITS-1, that digit is cleared to 0, state = ENTRY.
- DONE, enter event:
  - WRAP_EN=1: all digits = 0, cursor = 0, negative = 0, state = ENTRY.
  - WRAP_EN=0: ignored, no err_pulse.
- Sign event: toggles negative in either state. It is processed in parallel with any enter/back event in the same cycle.
- Simultaneous enter and back in the same cycle: back wins and enter is dropped; no err_pulse.
- entry_done = (state == DONE).
- digits_out, per position p:
  - In ENTRY with p == cursor: live preview, combinational from sw_digit. The code is sw_digit if <= 9, else 4'hA.
  - Otherwise, if p > cursor in ENTRY and BLANK_UNUSED = 1: 4'hA.
  - Otherwise: the stored digit.
  - In DONE, all positions show stored digits.
- Stored digits are always 0-9; the 4'hA/4'hB codes are never stored.
- The cursor never exceeds NUM_DIGITS and never wraps below 0.

Test Plan:
1. Bench uses DEBOUNCE_CYCLES=4, NUM_DIGITS=3. Hold rst low 1 cycle -> digits_out=12'h000, sign_out=4'hA, cursor=0, entry_done=0.
2. Enter 7, 2, 5 with clean presses -> after the third press digits_out=12'h527, cursor=3, entry_done=1. Each update lands exactly 7 cycles after the raw key goes low.
3. Bounce key_enter_n low/high every 2 cycles for 20 cycles, then hold low -> exactly one store. Holding for 100 cycles -> no further stores.
4. Press enter with sw_digit=4'hC at cursor 1 -> err_pulse high for 1 cycle, cursor stays 1, position 1 previews 4'hA.
5. From DONE with value 527, press back -> state ENTRY, cursor=2, position 2 previews sw_digit. Back twice more -> cursor 0; a further back -> no change.
6. Sign press plus simultaneous enter/back in the same cycle -> sign_out toggles to 4'hB, back applied, enter dropped. WRAP_EN=1 build: enter in DONE -> all 0, cursor 0, sign_out=4'hA.

Source files
------------

// File: rtl/bcd_entry_ctrl.sv
// bcd_entry_ctrl: debounced BCD number-entry controller for the board demos.
// The user keys in digits least-significant first, with backspace and sign toggle.
// The block drives per-digit display codes (0-9, 4'hA = OFF) and a sign code
// (4'hA = positive, 4'hB = negative) into the seven_seg decoders.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-low
//   key_enter_n  raw enter key, active-low, asynchronous
//   key_back_n   raw backspace key, active-low, asynchronous
//   key_sign_n   raw sign-toggle key, active-low, asynchronous
//   sw_digit     candidate digit from the switches
//   digits_out   per-position display codes, position 0 in [3:0]
//   sign_out     4'hB when negative, 4'hA when positive
//   cursor       next position to be written
//   entry_done   high while the value is complete
//   err_pulse    one-cycle pulse when an enter press carries a non-BCD digit
module bcd_entry_ctrl #(
    parameter int unsigned NUM_DIGITS      = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned WRAP_EN         = 0,
    parameter int unsigned BLANK_UNUSED    = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  key_enter_n,
    input  logic                                  key_back_n,
    input  logic                                  key_sign_n,
    input  logic [3:0]                            sw_digit,
    output logic [4*NUM_DIGITS-1:0]               digits_out,
    output logic [3:0]                            sign_out,
    output logic [$clog2(NUM_DIGITS+1)-1:0]       cursor,
    output logic                                  entry_done,
    output logic                                  err_pulse
);

    localparam int unsigned CW  = $clog2(NUM_DIGITS + 1);
    localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned NK  = 3;
    localparam logic [3:0] CODE_OFF = 4'hA;
    localparam logic [3:0] CODE_NEG = 4'hB;

    typedef enum logic {ST_ENTRY, ST_DONE} state_t;

    logic [NK-1:0] key_raw;
    logic [NK-1:0] key_press;
    logic          enter_ev;
    logic          back_ev;
    logic          sign_ev;

    assign key_raw  = {key_sign_n, key_back_n, key_enter_n};
    assign enter_ev = key_press[0];
    assign back_ev  = key_press[1];
    assign sign_ev  = key_press[2];

    // Per-key synchroniser, stable-level debouncer and press-edge pulse
    for (genvar k = 0; k < NK; k++) begin : g_key
        logic           sync1;
        logic           sync2;
        logic           level;
        logic           press;
        logic [DBW-1:0] cnt;

        always_ff @(posedge clk) begin
            if (!rst) begin
                sync1 <= 1'b1;
                sync2 <= 1'b1;
                level <= 1'b1;
                press <= 1'b0;
                cnt   <= '0;
            end else begin
                sync1 <= key_raw[k];
                sync2 <= sync1;
                press <= 1'b0;
                if (sync2 == level) begin
                    cnt <= '0;
                end else if (cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    // Level accepted; only a falling debounced edge is a press
                    cnt   <= '0;
                    level <= sync2;
                    press <= ~sync2;
                end else begin
                    cnt <= cnt + DBW'(1);
                end
            end
        end

        assign key_press[k] = press;
    end

    state_t        state_q, state_d;
    logic [CW-1:0] cur_q, cur_d;
    logic [3:0]    dig_q [NUM_DIGITS];
    logic [3:0]    dig_d [NUM_DIGITS];
    logic          neg_q, neg_d;
    logic          err_q, err_d;

    // Next-state logic; back has priority over enter, sign runs alongside both
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        dig_d   = dig_q;
        neg_d   = neg_q ^ sign_ev;
        err_d   = 1'b0;

        if (back_ev) begin
            if (state_q == ST_DONE) begin
                cur_d                = CW'(NUM_DIGITS - 1);
                dig_d[NUM_DIGITS-1]  = '0;
                state_d              = ST_ENTRY;
            end else if (cur_q != '0) begin
                cur_d = cur_q - CW'(1);
                for (int unsigned p = 0; p < NUM_DIGITS; p++) begin
                    if (CW'(p) == cur_d) dig_d[p] = '0;
                end
            end
        end else if (enter_ev) begin
            if (state_q == ST_ENTRY) begin
                if (sw_digit <= 4'd9) begin
                    for (int unsigned p = 0; p < NUM_DIGITS; p++) begin
                        if (CW'(p) == cur_q) dig_d[p] = sw_digit;
                    end
                    cur_d = cur_q + CW'(1);
                    if (cur_d == CW'(NUM_DIGITS)) state_d = ST_DONE;
                end else begin
                    err_d = 1'b1;
                end
            end else if (WRAP_EN != 0) begin
                for (int unsigned p = 0; p < NUM_DIGITS; p++) dig_d[p] = '0;
                cur_d   = '0;
                neg_d   = sign_ev;
                state_d = ST_ENTRY;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_ENTRY;
            cur_q   <= '0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
            for (int unsigned p = 0; p < NUM_DIGITS; p++) dig_q[p] <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
            dig_q   <= dig_d;
        end
    end

    assign cursor     = cur_q;
    assign entry_done = (state_q == ST_DONE);
    assign err_pulse  = err_q;
    assign sign_out   = neg_q ? CODE_NEG : CODE_OFF;

    // Display codes: live switch preview at the cursor while entering
    always_comb begin
        digits_out = '0;
        for (int unsigned p = 0; p < NUM_DIGITS; p++) begin
            if (state_q == ST_ENTRY && CW'(p) == cur_q) begin
                digits_out[4*p +: 4] = (sw_digit <= 4'd9) ? sw_digit : CODE_OFF;
            end else if (state_q == ST_ENTRY && BLANK_UNUSED != 0 && CW'(p) > cur_q) begin
                digits_out[4*p +: 4] = CODE_OFF;
            end else begin
                digits_out[4*p +: 4] = dig_q[p];
            end
        end
    end

endmodule
